// File: rtl/comb_checker.sv
// -----------------------------------------------------------------------------
// comb_checker
//
// Purpose:
//   Checks up to eight implementations of a 4-input combinational function.
//   Each implementation's output is compared against a reference truth table.
//   One vector is handled at a time:
//     1. The checker accepts a vector.
//     2. It waits SETTLE_CYC cycles so the implementations can settle.
//     3. It samples every implementation output in a single CHECK cycle.
//   The checker tracks how many vectors were checked and how many failed.
//   It also records which of the 16 vectors have been checked (coverage).
//   The run completes once all 16 vectors are covered.
//
// Optional feature (build macro FIRST_FAIL_CAPTURE_EN):
//   When the macro is defined, the first failing vector and its mismatch mask
//   are captured after each start. When it is undefined, no capture registers
//   exist and the first_fail_* outputs are tied to zero.
//
// Parameters:
//   TRUTH_TABLE  expected Y; bit k is the output for {A,B,C,D} = k
//   NUM_IMPL     number of implementations checked in parallel (1..8)
//   SETTLE_CYC   cycles between vector acceptance and sampling (1..15)
//
// Ports:
//   clk               sole clock, rising edge
//   rst               synchronous active-high reset, overrides everything
//   start             pulse; begins a run from IDLE or DONE
//   vec_valid         stimulus vector offered
//   vec_ready         checker accepts a vector this cycle (WAIT only)
//   vec[3:0]          applied input vector {A,B,C,D}
//   y_in[NUM_IMPL-1:0] implementation outputs, bit i = implementation i
//   busy              high in WAIT, SETTLE and CHECK
//   done              high in DONE
//   pass              high in DONE when no vector failed
//   chk_cnt[7:0]      vectors checked, saturating at 255
//   err_cnt[7:0]      vectors with any mismatch, saturating at 255
//   cov_map[15:0]     bit k set once vector k has been checked
//   first_fail_valid  a failure has been captured since start
//   first_fail_vec    vector of the first failure
//   first_fail_mask   mismatch mask of the first failure
//   state_dbg[2:0]    current FSM state, for debug and checker binding
//
// Handshake:
//   A vector transfers on a rising edge where vec_valid && vec_ready.
//   vec_ready does not depend on vec_valid.
//   vec_valid may be held low in WAIT indefinitely.
//   vec is only sampled on the transfer edge.
// -----------------------------------------------------------------------------
module comb_checker #(
  parameter logic [15:0] TRUTH_TABLE = 16'h6996,
  parameter int          NUM_IMPL    = 4,
  parameter int          SETTLE_CYC  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [3:0]          vec,
  input  logic [NUM_IMPL-1:0] y_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          chk_cnt,
  output logic [7:0]          err_cnt,
  output logic [15:0]         cov_map,
  output logic                first_fail_valid,
  output logic [3:0]          first_fail_vec,
  output logic [NUM_IMPL-1:0] first_fail_mask,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The settle counter is loaded with SETTLE_CYC-1 on acceptance.
  // It counts down to zero, so SETTLE lasts exactly SETTLE_CYC cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            vec_q;
  logic [3:0]            settle_cnt;
  logic                  start_run;
  logic                  expected_y;
  logic [NUM_IMPL-1:0]   mask;
  logic                  mask_any;
  logic [15:0]           cov_map_next;

  // A run can only be (re)started from IDLE or DONE.
  // start is ignored in every other state.
  assign start_run    = start && ((state_q == IDLE) || (state_q == DONE));

  assign expected_y   = TRUTH_TABLE[vec_q];
  assign mask         = y_in ^ {NUM_IMPL{expected_y}};
  assign mask_any     = |mask;

  // Coverage including the vector being checked this cycle.
  // This value decides whether CHECK moves to DONE or back to WAIT.
  assign cov_map_next = cov_map | (16'd1 << vec_q);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake output
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    vec_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_run) state_d = WAIT;
      end
      WAIT: begin
        vec_ready = 1'b1;
        if (vec_valid) state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_d = CHECK;
      end
      CHECK: begin
        state_d = (cov_map_next == 16'hFFFF) ? DONE : WAIT;
      end
      DONE: begin
        if (start_run) state_d = WAIT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q == WAIT) || (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_cnt == 8'd0);
  assign state_dbg = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: latched vector, settle counter, result counters, coverage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= 4'd0;
      settle_cnt <= 4'd0;
      chk_cnt    <= 8'd0;
      err_cnt    <= 8'd0;
      cov_map    <= 16'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_run) begin
            chk_cnt <= 8'd0;
            err_cnt <= 8'd0;
            cov_map <= 16'd0;
          end
        end
        WAIT: begin
          if (vec_valid) begin
            vec_q      <= vec;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        CHECK: begin
          // y_in is sampled only here.
          // Both counters stick at 255 instead of wrapping.
          if (chk_cnt != 8'hFF) chk_cnt <= chk_cnt + 8'd1;
          if (mask_any && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
          cov_map <= cov_map_next;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // First-failure capture
  // ---------------------------------------------------------------------------
`ifdef FIRST_FAIL_CAPTURE_EN
  logic                ff_valid_q;
  logic [3:0]          ff_vec_q;
  logic [NUM_IMPL-1:0] ff_mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= 4'd0;
      ff_mask_q  <= '0;
    end else if (start_run) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= 4'd0;
      ff_mask_q  <= '0;
    end else if ((state_q == CHECK) && mask_any && !ff_valid_q) begin
      // Only the first failure after start is kept.
      // Later failures leave the capture untouched.
      ff_valid_q <= 1'b1;
      ff_vec_q   <= vec_q;
      ff_mask_q  <= mask;
    end
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_mask  = ff_mask_q;
`else
  assign first_fail_valid = 1'b0;
  assign first_fail_vec   = 4'd0;
  assign first_fail_mask  = '0;
`endif

endmodule

// File: tb/tb_comb_checker.sv
// -----------------------------------------------------------------------------
// tb_comb_checker
//
// Self-checking bench for comb_checker.
//   - The DUT is built with SETTLE_CYC = 3.
//   - All inputs are driven on the falling clock edge.
//   - All outputs are sampled on the falling clock edge.
//   - A behavioural model tracks the expected results of a run.
// -----------------------------------------------------------------------------
module tb_comb_checker;

  localparam int          NI     = 4;
  localparam int          SETTLE = 3;
  localparam logic [15:0] TT     = 16'h6996;

  // ---------------------------------------------------------------------------
  // DUT connections
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst;
  logic          start;
  logic          vec_valid;
  logic          vec_ready;
  logic [3:0]    vec;
  logic [NI-1:0] y_in;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    chk_cnt;
  logic [7:0]    err_cnt;
  logic [15:0]   cov_map;
  logic          first_fail_valid;
  logic [3:0]    first_fail_vec;
  logic [NI-1:0] first_fail_mask;
  logic [2:0]    state_dbg;

  comb_checker #(
    .TRUTH_TABLE (TT),
    .NUM_IMPL    (NI),
    .SETTLE_CYC  (SETTLE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .vec_valid        (vec_valid),
    .vec_ready        (vec_ready),
    .vec              (vec),
    .y_in             (y_in),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .chk_cnt          (chk_cnt),
    .err_cnt          (err_cnt),
    .cov_map          (cov_map),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .first_fail_mask  (first_fail_mask),
    .state_dbg        (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int            checks;
  int            errors;
  logic [15:0]   tt;
  logic [NI-1:0] exp_q[$];   // expected mismatch mask per in-flight vector
  int            exp_chk;
  int            exp_err;
  logic [15:0]   exp_cov;
  logic          exp_done;
  logic          exp_ffv;
  logic [3:0]    exp_ffvec;
  logic [NI-1:0] exp_ffmask;

  task automatic model_clear();
    exp_chk    = 0;
    exp_err    = 0;
    exp_cov    = 16'd0;
    exp_done   = 1'b0;
    exp_ffv    = 1'b0;
    exp_ffvec  = 4'd0;
    exp_ffmask = '0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  // Sends one vector through the full handshake.
  //   - Implementations listed in 'flip' produce the wrong output in CHECK.
  //   - During SETTLE every implementation output is inverted (a glitch).
  //     Sampling at the wrong cycle therefore shows up as an error.
  //   - Protocol timing and the updated results are checked on completion.
  task automatic send_vec(input logic [3:0] v, input logic [NI-1:0] flip);
    int            guard;
    logic [NI-1:0] good;
    logic [NI-1:0] m;
    logic [NI-1:0] ffm_exp;
    logic [3:0]    ffv_exp_vec;
    logic          ffv_exp;
    good  = {NI{tt[v]}};
    guard = 0;
    while (vec_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (vec_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout vec=%0d vec_ready=%b required 1", v, vec_ready);
      return;
    end
    vec       = v;
    vec_valid = 1'b1;
    y_in      = ~good;
    exp_q.push_back(flip);
    @(negedge clk);
    vec_valid = 1'b0;
    vec       = 4'($urandom);
    for (int i = 0; i < SETTLE; i++) begin
      checks++;
      if (vec_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL settle_ready vec=%0d cyc=%0d ready=%b busy=%b required 0/1",
                 v, i, vec_ready, busy);
      end
      y_in = ~good;
      @(negedge clk);
    end
    // CHECK cycle
    checks++;
    if (vec_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL check_ready vec=%0d ready=%b busy=%b required 0/1", v, vec_ready, busy);
    end
    y_in = good ^ flip;
    @(negedge clk);
    y_in = ~good;
    // Update the model from the behavioural rules.
    m = exp_q.pop_front();
    if (exp_chk < 255) exp_chk++;
    if (m != '0) begin
      if (exp_err < 255) exp_err++;
      if (!exp_ffv) begin
        exp_ffv    = 1'b1;
        exp_ffvec  = v;
        exp_ffmask = m;
      end
    end
    exp_cov[v] = 1'b1;
    exp_done   = (exp_cov == 16'hFFFF);
    checks++;
    if (chk_cnt !== 8'(exp_chk)) begin
      errors++;
      $display("FAIL chk_cnt vec=%0d got %0d expected %0d", v, chk_cnt, exp_chk);
    end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL err_cnt vec=%0d got %0d expected %0d", v, err_cnt, exp_err);
    end
    checks++;
    if (cov_map !== exp_cov) begin
      errors++;
      $display("FAIL cov_map vec=%0d got %h expected %h", v, cov_map, exp_cov);
    end
    checks++;
    if (done !== exp_done || vec_ready !== !exp_done || busy !== !exp_done) begin
      errors++;
      $display("FAIL post_check_state vec=%0d done=%b ready=%b busy=%b expected done=%b",
               v, done, vec_ready, busy, exp_done);
    end
    checks++;
    if (pass !== (exp_done && exp_err == 0)) begin
      errors++;
      $display("FAIL pass vec=%0d got %b expected %b", v, pass, exp_done && exp_err == 0);
    end
`ifdef FIRST_FAIL_CAPTURE_EN
    ffv_exp     = exp_ffv;
    ffv_exp_vec = exp_ffvec;
    ffm_exp     = exp_ffmask;
`else
    ffv_exp     = 1'b0;
    ffv_exp_vec = 4'd0;
    ffm_exp     = '0;
`endif
    checks++;
    if (first_fail_valid !== ffv_exp || first_fail_vec !== ffv_exp_vec ||
        first_fail_mask !== ffm_exp) begin
      errors++;
      $display("FAIL first_fail vec=%0d got %b/%0d/%b expected %b/%0d/%b", v,
               first_fail_valid, first_fail_vec, first_fail_mask,
               ffv_exp, ffv_exp_vec, ffm_exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // rst must win over start and vec_valid driven in the same cycles.
    rst       = 1'b1;
    start     = 1'b1;
    vec_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    vec_valid = 1'b0;
    model_clear();
    checks++;
    if (vec_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ready=%b busy=%b done=%b pass=%b required 0",
               vec_ready, busy, done, pass);
    end
    checks++;
    if (chk_cnt !== 8'd0 || err_cnt !== 8'd0 || cov_map !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts chk=%0d err=%0d cov=%h required 0",
               chk_cnt, err_cnt, cov_map);
    end
    checks++;
    if (first_fail_valid !== 1'b0 || first_fail_vec !== 4'd0 || first_fail_mask !== '0) begin
      errors++;
      $display("FAIL reset_first_fail got %b/%0d/%b required 0",
               first_fail_valid, first_fail_vec, first_fail_mask);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold busy=%b ready=%b required 0", busy, vec_ready);
    end
  endtask

  task automatic test_full_sweep();
    do_start();
    checks++;
    if (busy !== 1'b1 || vec_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_wait busy=%b ready=%b done=%b required 1/1/0",
               busy, vec_ready, done);
    end
    for (int v = 0; v < 16; v++) send_vec(4'(v), '0);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || chk_cnt !== 8'd16 || err_cnt !== 8'd0 ||
        cov_map !== 16'hFFFF) begin
      errors++;
      $display("FAIL sweep_result done=%b pass=%b chk=%0d err=%0d cov=%h required 1/1/16/0/ffff",
               done, pass, chk_cnt, err_cnt, cov_map);
    end
  endtask

  task automatic test_sweep_errors();
    logic [7:0] hold_chk;
    do_start();
    checks++;
    if (chk_cnt !== 8'd0 || cov_map !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear chk=%0d cov=%h done=%b required 0/0/0",
               chk_cnt, cov_map, done);
    end
    for (int v = 0; v < 16; v++)
      send_vec(4'(v), (v == 5 || v == 9) ? 4'b0100 : 4'b0000);
    checks++;
    if (pass !== 1'b0 || err_cnt !== 8'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL error_sweep pass=%b err=%0d done=%b required 0/2/1", pass, err_cnt, done);
    end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++;
    if (first_fail_vec !== 4'd5 || first_fail_mask !== 4'b0100 || first_fail_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_fail_sweep got %b/%0d/%b required 1/5/0100",
               first_fail_valid, first_fail_vec, first_fail_mask);
    end
`endif
    // DONE must stay stable while inputs wiggle without start.
    hold_chk = chk_cnt;
    repeat (5) begin
      vec_valid = 1'($urandom);
      vec       = 4'($urandom);
      y_in      = NI'($urandom);
      @(negedge clk);
    end
    vec_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || chk_cnt !== hold_chk || err_cnt !== 8'd2 || cov_map !== 16'hFFFF) begin
      errors++;
      $display("FAIL done_hold done=%b chk=%0d err=%0d cov=%h required 1/16/2/ffff",
               done, chk_cnt, err_cnt, cov_map);
    end
  endtask

  task automatic test_saturation();
    do_start();
    for (int v = 0; v < 15; v++)
      for (int r = 0; r < 20; r++)
        send_vec(4'(v), NI'($urandom_range(1, (1 << NI) - 1)));
    checks++;
    if (chk_cnt !== 8'd255 || err_cnt !== 8'd255 || done !== 1'b0) begin
      errors++;
      $display("FAIL saturate_pre chk=%0d err=%0d done=%b required 255/255/0",
               chk_cnt, err_cnt, done);
    end
    send_vec(4'd15, '0);
    checks++;
    if (chk_cnt !== 8'd255 || err_cnt !== 8'd255 || done !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL saturate_end chk=%0d err=%0d done=%b pass=%b required 255/255/1/0",
               chk_cnt, err_cnt, done, pass);
    end
  endtask

  task automatic test_reset_mid_run();
    do_start();
    for (int v = 0; v < 7; v++) send_vec(4'(v), 4'b0001);
    vec       = 4'd7;
    vec_valid = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_ready !== 1'b0 || pass !== 1'b0 ||
        chk_cnt !== 8'd0 || err_cnt !== 8'd0 || cov_map !== 16'd0 ||
        first_fail_valid !== 1'b0 || first_fail_vec !== 4'd0 || first_fail_mask !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b ready=%b chk=%0d err=%0d cov=%h ffv=%b required all 0",
               busy, done, vec_ready, chk_cnt, err_cnt, cov_map, first_fail_valid);
    end
    do_start();
    for (int v = 0; v < 16; v++) send_vec(4'(v), '0);
    checks++;
    if (chk_cnt !== 8'd16 || pass !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_sweep chk=%0d pass=%b required 16/1", chk_cnt, pass);
    end
  endtask

  task automatic test_start_ignored();
    do_start();
    for (int v = 0; v < 3; v++) send_vec(4'(v), '0);
    // Pulse start while in WAIT; the run must carry on untouched.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (chk_cnt !== 8'd3 || busy !== 1'b1 || cov_map !== 16'h0007) begin
      errors++;
      $display("FAIL start_in_wait chk=%0d busy=%b cov=%h required 3/1/0007",
               chk_cnt, busy, cov_map);
    end
    for (int v = 3; v < 16; v++) send_vec(4'(v), '0);
    checks++;
    if (chk_cnt !== 8'd16 || done !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_end chk=%0d done=%b required 16/1", chk_cnt, done);
    end
  endtask

  task automatic test_random();
    int n;
    do_start();
    n = 0;
    while (!exp_done && n < 300) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_vec(4'($urandom), ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL random_done done=%b after %0d vectors required 1", done, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    checks    = 0;
    errors    = 0;
    tt        = TT;
    rst       = 1'b1;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec       = 4'd0;
    y_in      = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_full_sweep();
    test_sweep_errors();
    test_saturation();
    test_reset_mid_run();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/comb_checker.md
COMB_CHECKER -- requirements
Module: comb_checker

Interface
REQ-001 Parameter TRUTH_TABLE, 16'h6996, expected Y per input vector; bit k is the expected output for {A,B,C,D}=k.
REQ-002 Parameter NUM_IMPL, 4, number of implementations checked in parallel (1..8).
REQ-003 Parameter SETTLE_CYC, 2, cycles between vector acceptance and output sampling (1..15).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  pulse; begins a check run from IDLE or DONE.
REQ-007 vec_valid  input  1  stimulus vector offered.
REQ-008 vec_ready  output  1  checker accepts vector this cycle.
REQ-009 vec  input  4  applied input vector {A,B,C,D}.
REQ-010 y_in  input  NUM_IMPL  Y outputs of each implementation under test, bit i = implementation i.
REQ-011 busy  output  1  high in any state other than IDLE and DONE.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  valid when done; high iff err_cnt==0.
REQ-014 chk_cnt  output  8  vectors checked, saturating at 255.
REQ-015 err_cnt  output  8  vectors with at least one mismatching implementation, saturating at 255.
REQ-016 cov_map  output  16  bit k set once vector k has been checked.
REQ-017 first_fail_valid / first_fail_vec[3:0] / first_fail_mask[NUM_IMPL-1:0]  outputs  first-failure capture (see Configuration).

Function
REQ-018 The block SHALL implement states IDLE, WAIT, SETTLE, CHECK, DONE.
REQ-019 IDLE/DONE: vec_ready=0; start SHALL clear chk_cnt, err_cnt, cov_map, first-fail outputs and enter WAIT next cycle.
REQ-020 WAIT: vec_ready=1; vec_valid&&vec_ready at edge N SHALL latch vec and enter SETTLE; vec_valid low keeps WAIT indefinitely.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles (N+1..N+SETTLE_CYC) with vec_ready=0, then enter CHECK.
REQ-022 CHECK (cycle N+SETTLE_CYC+1) SHALL sample y_in and form mask = y_in XOR {NUM_IMPL{TRUTH_TABLE[latched vec]}}.
REQ-023 In CHECK: chk_cnt+1; err_cnt+1 iff mask!=0; cov_map[vec]=1; both counters hold at 255, never wrap.
REQ-024 After CHECK, the block SHALL enter DONE if the updated cov_map==16'hFFFF, else WAIT (vec_ready=1 at N+SETTLE_CYC+2).
REQ-025 Repeated vectors SHALL be checked and counted again; cov_map unaffected beyond its set bit.
REQ-026 DONE SHALL hold all results stable until start or rst.
REQ-027 start in WAIT, SETTLE or CHECK SHALL be ignored.
REQ-028 y_in changes outside CHECK SHALL have no effect.

Reset
REQ-029 rst SHALL override all inputs including start, same cycle.
REQ-030 After rst: state IDLE, vec_ready=0, busy=0, done=0, pass=0, chk_cnt=0, err_cnt=0, cov_map=0, first_fail_valid=0, first_fail_vec=0, first_fail_mask=0.
REQ-031 rst mid-run (any state) SHALL abandon the in-flight vector without counting it.

Configuration
REQ-032 Macro FIRST_FAIL_CAPTURE_EN defined: on the first CHECK with mask!=0 after start, first_fail_valid=1, first_fail_vec=vec, first_fail_mask=mask; later failures SHALL NOT overwrite.
REQ-033 Macro undefined: first_fail_valid, first_fail_vec, first_fail_mask SHALL be constant 0 and no capture registers built; all other behaviour unchanged.

Verification
REQ-034 rst then start, vectors 0..15 in order, y_in = {4{TRUTH_TABLE[vec]}} -> done after 16th CHECK, pass=1, chk_cnt=16, err_cnt=0, cov_map=16'hFFFF.
REQ-035 Same sweep, implementation 2 inverted on vec=5 and vec=9 -> pass=0, err_cnt=2, with macro first_fail_vec=5, first_fail_mask=4'b0100.
REQ-036 SETTLE_CYC=3, vector accepted at edge 10 -> vec_ready low cycles 11..14, y_in sampled at cycle 14 only, vec_ready high at 15; y_in glitch at cycle 12 ignored.
REQ-037 Vectors 0..14 each sent 20 times then 15 -> chk_cnt saturates at 255, done only after vec=15.
REQ-038 rst asserted in SETTLE after 7 vectors -> all outputs at reset values next cycle; start then full sweep -> chk_cnt=16.
REQ-039 start pulsed in WAIT after 3 vectors -> ignored, chk_cnt continues from 3.
